fft_input_framer: RTL
=====================

# fft_input_framer

Upstream feeder for the 16-point `butterfly_top_module`. It accepts a serial stream of complex samples over a valid/ready handshake and assembles them into 16-sample frames in a ping-pong buffer. It presents each completed frame on 32 parallel buses and toggles `new_input_flag` to launch the FFT. It holds that frame stable until the FFT reports completion via a rising edge of `fft_ready_flag`, while the next frame fills in the other bank.

## Interface
- `DATA_W`, 16, sample width (two's complement) for real and imag
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-low reset
- `s_valid`  in  1  upstream sample valid
- `s_ready`  out  1  framer can accept a sample this cycle
- `s_real`  in  DATA_W  sample real part
- `s_imag`  in  DATA_W  sample imag part
- `fft_ready_flag`  in  1  FFT completion level; a 0→1 transition marks the issued frame done
- `new_input_flag`  out  1  toggles once per issued frame; wires to the FFT input of the same name
- `input_realN`  out  DATA_W  N=0..15, real part of presented frame sample N
- `input_imagN`  out  DATA_W  N=0..15, imag part of presented frame sample N
- `frame_count`  out  16  frames issued since reset, wraps 0xFFFF→0

## Operation
- Storage: two banks, each 16×(real, imag). `fill_sel` selects the bank being written. Outputs always drive the other bank (`~fill_sel`).
- Write index `wr_idx` runs 0..15. A sample is accepted on an edge where `s_valid && s_ready`. It is written to `bank[fill_sel][wr_idx]` and `wr_idx` increments.
- Accepting sample 15 sets `fill_full` and returns `wr_idx` to 0.
- `s_ready = ~fill_full` (registered state, no combinational path from `s_valid`).
- Issue FSM has two states:
  - IDLE: no frame outstanding. If `fill_full`, the next edge performs a swap: `fill_sel` flips, `fill_full` clears, `new_input_flag` toggles, `frame_count` increments, and the FSM goes to BUSY.
  - BUSY: presented bank frozen. Detect a rising edge with `fft_rdy_d` (previous `fft_ready_flag`). On `fft_ready_flag && !fft_rdy_d`, go to IDLE.
- Rising edges of `fft_ready_flag` while IDLE are ignored. A constant-high level counts only once.
- In BUSY, filling continues into `fill_sel`. If that bank fills, `s_ready` stays low until BUSY→IDLE, and the swap happens on the following edge.
- Samples are never dropped or overwritten. Backpressure is the only flow-control mechanism.
- Sample order: the Nth accepted sample of a frame appears on `input_realN`/`input_imagN`. No bit reversal (the FFT performs it).

## Timing
- Reset (`rst`=0 at an edge):
  - Both banks are zeroed, so all `input_real*` and `input_imag*` are 0.
  - `new_input_flag`=0, `frame_count`=0, `fill_sel`=0, `wr_idx`=0, `fill_full`=0, FSM=IDLE, `fft_rdy_d`=0.
  - `s_ready`=1 from the first cycle after reset.
- Reset mid-fill or mid-BUSY discards all partial and outstanding state with no toggle.
- Latency with FSM IDLE: if sample 15 is accepted at edge t, then at edge t+1 `new_input_flag` toggles and the new `input_*` values are visible. `s_ready` is low for exactly the one cycle between t and t+1.
- Full-rate throughput: 16 samples per 17 cycles when the FFT completes before the next frame fills.
- If a `fft_ready_flag` rising edge and `fill_full` both occur at edge t, BUSY→IDLE happens at t and the swap happens at t+1.
- Presented outputs change only on a swap edge, always simultaneously with the `new_input_flag` toggle.

## Test plan
- **Single frame:** reset, then 16 back-to-back samples with real=10·k, imag=−k (k=0..15).
  - `new_input_flag` goes 0→1 one edge after the 16th accept.
  - `input_real5`=50, `input_imag5`=−5 (0xFFFB).
  - `frame_count`=1; `s_ready` low for 1 cycle.
- **Backpressure:** while BUSY, stream a second frame with real=100+k.
  - After 16 accepts, `s_ready` stays 0 and outputs still show frame 1.
  - Raise `fft_ready_flag` at edge t: at t+1 the flag toggles to 0, `input_real0`=100, `frame_count`=2, and `s_ready`=1.
- **Gappy input:** `s_valid` asserted every 3rd cycle for 16 samples. The frame is assembled in order, with a single toggle after the last accept.
- **Stale ready:**
  - Hold `fft_ready_flag`=1 from reset; the first frame issues normally and the FSM stays BUSY.
  - A second frame stalls until `fft_ready_flag` drops and re-rises.
- **Mid-fill reset:** accept 7 samples, then pulse `rst`=0 for one edge.
  - All outputs are 0, `new_input_flag`=0, `frame_count`=0.
  - The next 16 samples form frame 1 starting at index 0.
- **Simultaneous events:** the 16th accept of frame 2 lands on the same edge as the `fft_ready_flag` rise. The swap occurs exactly one edge later, and no sample is lost or duplicated.

Source files
------------

// File: rtl/fft_input_framer.sv
// rtl/fft_input_framer.sv - ping-pong framer assembling 16-sample complex frames for the FFT
module fft_input_framer #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_real,
    input  logic [DATA_W-1:0] s_imag,
    input  logic              fft_ready_flag,
    output logic              new_input_flag,
    output logic [DATA_W-1:0] input_real0,
    output logic [DATA_W-1:0] input_real1,
    output logic [DATA_W-1:0] input_real2,
    output logic [DATA_W-1:0] input_real3,
    output logic [DATA_W-1:0] input_real4,
    output logic [DATA_W-1:0] input_real5,
    output logic [DATA_W-1:0] input_real6,
    output logic [DATA_W-1:0] input_real7,
    output logic [DATA_W-1:0] input_real8,
    output logic [DATA_W-1:0] input_real9,
    output logic [DATA_W-1:0] input_real10,
    output logic [DATA_W-1:0] input_real11,
    output logic [DATA_W-1:0] input_real12,
    output logic [DATA_W-1:0] input_real13,
    output logic [DATA_W-1:0] input_real14,
    output logic [DATA_W-1:0] input_real15,
    output logic [DATA_W-1:0] input_imag0,
    output logic [DATA_W-1:0] input_imag1,
    output logic [DATA_W-1:0] input_imag2,
    output logic [DATA_W-1:0] input_imag3,
    output logic [DATA_W-1:0] input_imag4,
    output logic [DATA_W-1:0] input_imag5,
    output logic [DATA_W-1:0] input_imag6,
    output logic [DATA_W-1:0] input_imag7,
    output logic [DATA_W-1:0] input_imag8,
    output logic [DATA_W-1:0] input_imag9,
    output logic [DATA_W-1:0] input_imag10,
    output logic [DATA_W-1:0] input_imag11,
    output logic [DATA_W-1:0] input_imag12,
    output logic [DATA_W-1:0] input_imag13,
    output logic [DATA_W-1:0] input_imag14,
    output logic [DATA_W-1:0] input_imag15,
    output logic [15:0]       frame_count
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state;
    state_t            next_state;
    logic              swap;
    logic              fill_sel;
    logic              out_sel;
    logic              fill_full;
    logic [3:0]        wr_idx;
    logic              fft_rdy_d;
    logic              accept;
    logic [DATA_W-1:0] bank_real [2][16];
    logic [DATA_W-1:0] bank_imag [2][16];

    assign s_ready = ~fill_full;
    assign accept  = s_valid && s_ready;
    assign out_sel = ~fill_sel;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A completion rise seen while IDLE is deliberately ignored; only BUSY consumes it.
    always_comb begin
        next_state = state;
        swap       = 1'b0;
        case (state)
            IDLE: begin
                if (fill_full) begin
                    swap       = 1'b1;
                    next_state = BUSY;
                end
            end
            BUSY: begin
                if (fft_ready_flag && !fft_rdy_d) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fill_sel       <= 1'b0;
            fill_full      <= 1'b0;
            wr_idx         <= '0;
            fft_rdy_d      <= 1'b0;
            new_input_flag <= 1'b0;
            frame_count    <= '0;
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < 16; i++) begin
                    bank_real[b][i] <= '0;
                    bank_imag[b][i] <= '0;
                end
            end
        end else begin
            fft_rdy_d <= fft_ready_flag;
            // accept and swap never coincide: swap requires fill_full, which holds s_ready low
            if (accept) begin
                bank_real[fill_sel][wr_idx] <= s_real;
                bank_imag[fill_sel][wr_idx] <= s_imag;
                wr_idx                      <= wr_idx + 4'd1;
                if (wr_idx == 4'd15) begin
                    fill_full <= 1'b1;
                end
            end
            if (swap) begin
                fill_sel       <= ~fill_sel;
                fill_full      <= 1'b0;
                new_input_flag <= ~new_input_flag;
                frame_count    <= frame_count + 16'd1;
            end
        end
    end

    assign input_real0  = bank_real[out_sel][0];
    assign input_real1  = bank_real[out_sel][1];
    assign input_real2  = bank_real[out_sel][2];
    assign input_real3  = bank_real[out_sel][3];
    assign input_real4  = bank_real[out_sel][4];
    assign input_real5  = bank_real[out_sel][5];
    assign input_real6  = bank_real[out_sel][6];
    assign input_real7  = bank_real[out_sel][7];
    assign input_real8  = bank_real[out_sel][8];
    assign input_real9  = bank_real[out_sel][9];
    assign input_real10 = bank_real[out_sel][10];
    assign input_real11 = bank_real[out_sel][11];
    assign input_real12 = bank_real[out_sel][12];
    assign input_real13 = bank_real[out_sel][13];
    assign input_real14 = bank_real[out_sel][14];
    assign input_real15 = bank_real[out_sel][15];
    assign input_imag0  = bank_imag[out_sel][0];
    assign input_imag1  = bank_imag[out_sel][1];
    assign input_imag2  = bank_imag[out_sel][2];
    assign input_imag3  = bank_imag[out_sel][3];
    assign input_imag4  = bank_imag[out_sel][4];
    assign input_imag5  = bank_imag[out_sel][5];
    assign input_imag6  = bank_imag[out_sel][6];
    assign input_imag7  = bank_imag[out_sel][7];
    assign input_imag8  = bank_imag[out_sel][8];
    assign input_imag9  = bank_imag[out_sel][9];
    assign input_imag10 = bank_imag[out_sel][10];
    assign input_imag11 = bank_imag[out_sel][11];
    assign input_imag12 = bank_imag[out_sel][12];
    assign input_imag13 = bank_imag[out_sel][13];
    assign input_imag14 = bank_imag[out_sel][14];
    assign input_imag15 = bank_imag[out_sel][15];

endmodule
